// File: rtl/counter_seq_ctrl.sv
// Two-digit BCD up/down counter with start/stop/pause sequencing.
// Prescaled stepping, one-shot or wrap mode, 7-segment digit outputs.
module counter_seq_ctrl #(
    parameter int PRESCALE = 4
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       direction,
    input  logic       oneshot,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [7:0] seg_ones,
    output logic [7:0] seg_tens,
    output logic [1:0] state,
    output logic       tc
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       tc_q, tc_d;
    logic [7:0] pre_q, pre_d;
    logic       start_q, stop_q;

    logic       start_edge, stop_edge, step;
    logic [3:0] nx_ones, nx_tens;
    logic       wrap, terminal;

    function automatic logic [3:0] sat9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    assign start_edge = start & ~start_q;
    assign stop_edge  = stop & ~stop_q;
    assign step       = (state_q == RUN) && (pre_q == PRE_MAX);

    // BCD neighbour of the current count in the requested direction
    always_comb begin
        nx_ones = ones_q;
        nx_tens = tens_q;
        wrap    = 1'b0;
        if (direction) begin
            if (ones_q >= 4'd9) begin
                nx_ones = 4'd0;
                if (tens_q >= 4'd9) begin
                    nx_tens = 4'd0;
                    wrap    = 1'b1;
                end else begin
                    nx_tens = tens_q + 4'd1;
                end
            end else begin
                nx_ones = ones_q + 4'd1;
            end
        end else begin
            if (ones_q == 4'd0) begin
                nx_ones = 4'd9;
                if (tens_q == 4'd0) begin
                    nx_tens = 4'd9;
                    wrap    = 1'b1;
                end else begin
                    nx_tens = tens_q - 4'd1;
                end
            end else begin
                nx_ones = ones_q - 4'd1;
            end
        end
        terminal = direction ? (nx_ones == 4'd9 && nx_tens == 4'd9)
                             : (nx_ones == 4'd0 && nx_tens == 4'd0);
    end

    // Sequencer: state transitions, loads and count steps
    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        tc_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge && !stop_edge) begin
                    state_d = RUN;
                end else if (load) begin
                    ones_d = sat9(load_value[3:0]);
                    tens_d = sat9(load_value[7:4]);
                end
            end
            RUN: begin
                if (stop_edge) begin
                    state_d = PAUSE;
                end else if (step) begin
                    ones_d = nx_ones;
                    tens_d = nx_tens;
                    if (oneshot) begin
                        if (terminal) begin
                            tc_d    = 1'b1;
                            state_d = DONE;
                        end
                    end else begin
                        tc_d = wrap;
                    end
                end
            end
            PAUSE: begin
                if (load) begin
                    ones_d  = sat9(load_value[3:0]);
                    tens_d  = sat9(load_value[7:4]);
                    state_d = IDLE;
                end else if (start_edge && !stop_edge) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (load) begin
                    ones_d  = sat9(load_value[3:0]);
                    tens_d  = sat9(load_value[7:4]);
                    state_d = IDLE;
                end else if (stop_edge) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler only runs while staying in RUN, so each entry restarts it
    always_comb begin
        pre_d = 8'd0;
        if (state_q == RUN && state_d == RUN) begin
            pre_d = (pre_q == PRE_MAX) ? 8'd0 : pre_q + 8'd1;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            tc_q    <= 1'b0;
            pre_q   <= 8'd0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            tc_q    <= tc_d;
            pre_q   <= pre_d;
            start_q <= start;
            stop_q  <= stop;
        end
    end

    assign ones     = ones_q;
    assign tens     = tens_q;
    assign state    = state_q;
    assign tc       = tc_q;
    assign seg_ones = seg7(ones_q);
    assign seg_tens = seg7(tens_q);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl at PRESCALE=4.
// Expected per-cycle outputs are queued with the stimulus and checked at negedge.
module tb_counter_seq_ctrl;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       direction = 1'b1;
    logic       oneshot = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [3:0] ones, tens;
    logic [7:0] seg_ones, seg_tens;
    logic [1:0] state;
    logic       tc;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      tag;
        logic [7:0] cnt;
        logic [1:0] st;
        logic       tc;
    } exp_t;

    exp_t sb[$];

    counter_seq_ctrl #(.PRESCALE(4)) dut (
        .clk_2(clk_2),
        .reset(reset),
        .start(start),
        .stop(stop),
        .direction(direction),
        .oneshot(oneshot),
        .load(load),
        .load_value(load_value),
        .ones(ones),
        .tens(tens),
        .seg_ones(seg_ones),
        .seg_tens(seg_tens),
        .state(state),
        .tc(tc)
    );

    always #5 clk_2 = ~clk_2;

    function automatic logic [7:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Pop one expectation per cycle once the DUT outputs have settled
    always @(negedge clk_2) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "/cnt"}, 16'({tens, ones}), 16'(e.cnt));
            chk({e.tag, "/st"}, 16'(state), 16'(e.st));
            chk({e.tag, "/tc"}, 16'(tc), 16'(e.tc));
            chk({e.tag, "/so"}, 16'(seg_ones), 16'(seg_ref(e.cnt[3:0])));
            chk({e.tag, "/st7"}, 16'(seg_tens), 16'(seg_ref(e.cnt[7:4])));
        end
    end

    task automatic cyc(input string tag, input logic [7:0] cnt,
                       input logic [1:0] st, input logic t);
        exp_t e;
        e.tag = tag;
        e.cnt = cnt;
        e.st  = st;
        e.tc  = t;
        sb.push_back(e);
        @(posedge clk_2);
        @(negedge clk_2);
        #1;
    endtask

    task automatic hold(input string tag, input int n,
                        input logic [7:0] cnt, input logic [1:0] st);
        for (int i = 0; i < n; i++) cyc(tag, cnt, st, 1'b0);
    endtask

    task automatic chk_reset_now(input string tag);
        chk({tag, "/cnt"}, 16'({tens, ones}), 16'h0000);
        chk({tag, "/st"}, 16'(state), 16'd0);
        chk({tag, "/tc"}, 16'(tc), 16'd0);
        chk({tag, "/so"}, 16'(seg_ones), 16'h003F);
        chk({tag, "/st7"}, 16'(seg_tens), 16'h003F);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        #3 chk_reset_now("rst");
        @(negedge clk_2);
        #1 reset = 1'b0;

        // basic up count
        direction = 1'b1;
        oneshot   = 1'b0;
        start     = 1'b1;
        cyc("up_go", 8'h00, 2'd1, 1'b0);
        start = 1'b0;
        hold("up_w0", 3, 8'h00, 2'd1);
        cyc("up_s1", 8'h01, 2'd1, 1'b0);
        hold("up_w1", 3, 8'h01, 2'd1);
        cyc("up_s2", 8'h02, 2'd1, 1'b0);
        hold("up_w2", 3, 8'h02, 2'd1);
        cyc("up_s3", 8'h03, 2'd1, 1'b0);
        stop = 1'b1;
        cyc("up_stop", 8'h03, 2'd2, 1'b0);
        stop       = 1'b0;
        load       = 1'b1;
        load_value = 8'h98;
        cyc("pld98", 8'h98, 2'd0, 1'b0);

        // wrap 99 -> 00 with tc
        cyc("ild98", 8'h98, 2'd0, 1'b0);
        load  = 1'b0;
        start = 1'b1;
        cyc("wr_go", 8'h98, 2'd1, 1'b0);
        start = 1'b0;
        hold("wr_w0", 3, 8'h98, 2'd1);
        cyc("wr_99", 8'h99, 2'd1, 1'b0);
        hold("wr_w1", 3, 8'h99, 2'd1);
        cyc("wr_00", 8'h00, 2'd1, 1'b1);
        cyc("wr_tc0", 8'h00, 2'd1, 1'b0);
        hold("wr_w2", 2, 8'h00, 2'd1);
        stop = 1'b1;
        cyc("wr_stop", 8'h00, 2'd2, 1'b0);
        stop = 1'b0;

        // one-shot down to 00
        load       = 1'b1;
        load_value = 8'h02;
        cyc("os_ld", 8'h02, 2'd0, 1'b0);
        load      = 1'b0;
        direction = 1'b0;
        oneshot   = 1'b1;
        start     = 1'b1;
        cyc("os_go", 8'h02, 2'd1, 1'b0);
        start = 1'b0;
        hold("os_w0", 3, 8'h02, 2'd1);
        cyc("os_01", 8'h01, 2'd1, 1'b0);
        hold("os_w1", 3, 8'h01, 2'd1);
        cyc("os_00", 8'h00, 2'd3, 1'b1);
        hold("os_done", 6, 8'h00, 2'd3);

        // pause and resume
        load       = 1'b1;
        load_value = 8'h05;
        cyc("pa_ld", 8'h05, 2'd0, 1'b0);
        load      = 1'b0;
        direction = 1'b1;
        oneshot   = 1'b0;
        start     = 1'b1;
        cyc("pa_go", 8'h05, 2'd1, 1'b0);
        start = 1'b0;
        hold("pa_run", 2, 8'h05, 2'd1);
        stop = 1'b1;
        cyc("pa_stop", 8'h05, 2'd2, 1'b0);
        stop = 1'b0;
        hold("pa_hold", 20, 8'h05, 2'd2);
        start = 1'b1;
        cyc("pa_res", 8'h05, 2'd1, 1'b0);
        start = 1'b0;
        hold("pa_w", 3, 8'h05, 2'd1);
        cyc("pa_06", 8'h06, 2'd1, 1'b0);

        // simultaneous start/stop in PAUSE, saturating load
        stop = 1'b1;
        cyc("ss_stop", 8'h06, 2'd2, 1'b0);
        stop = 1'b0;
        cyc("ss_gap", 8'h06, 2'd2, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        cyc("ss_both", 8'h06, 2'd2, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        hold("ss_w", 2, 8'h06, 2'd2);
        load       = 1'b1;
        load_value = 8'hFA;
        cyc("sat_ld", 8'h99, 2'd0, 1'b0);
        load = 1'b0;
        cyc("sat_idle", 8'h99, 2'd0, 1'b0);

        // one-shot started at terminal value steps through it
        oneshot = 1'b1;
        start   = 1'b1;
        cyc("ot_go", 8'h99, 2'd1, 1'b0);
        start = 1'b0;
        hold("ot_w0", 3, 8'h99, 2'd1);
        cyc("ot_00", 8'h00, 2'd1, 1'b0);
        hold("ot_w1", 3, 8'h00, 2'd1);
        cyc("ot_01", 8'h01, 2'd1, 1'b0);

        // async reset while running at 47
        stop = 1'b1;
        cyc("ar_stop", 8'h01, 2'd2, 1'b0);
        stop       = 1'b0;
        load       = 1'b1;
        load_value = 8'h47;
        cyc("ar_ld", 8'h47, 2'd0, 1'b0);
        load  = 1'b0;
        start = 1'b1;
        cyc("ar_go", 8'h47, 2'd1, 1'b0);
        start = 1'b0;
        hold("ar_run", 2, 8'h47, 2'd1);
        #2 reset = 1'b1;
        #1 chk_reset_now("arst");
        @(negedge clk_2);
        #1 reset = 1'b0;
        hold("ar_idle", 3, 8'h00, 2'd0);

        // start held high through reset release
        #2 reset = 1'b1;
        start = 1'b1;
        #1 chk_reset_now("rst2");
        @(negedge clk_2);
        #1 reset = 1'b0;
        cyc("rs_go", 8'h00, 2'd1, 1'b0);
        cyc("rs_hold", 8'h00, 2'd1, 1'b0);
        start = 1'b0;

        @(negedge clk_2);
        #1 chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: PRESCALE, default 4, clk_2 cycles per count step (legal range 2..255).
REQ-002 The block SHALL have port clk_2, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, level input; a rising edge is a start command.
REQ-005 The block SHALL have port stop, input, 1, level input; a rising edge is a stop command.
REQ-006 The block SHALL have port direction, input, 1, count direction: 1 = up, 0 = down; sampled at each step.
REQ-007 The block SHALL have port oneshot, input, 1, mode select: 1 = halt at terminal value, 0 = wrap; sampled at each step.
REQ-008 The block SHALL have port load, input, 1, level-sensitive load request.
REQ-009 The block SHALL have port load_value, input, 8, two BCD digits: [7:4] tens, [3:0] ones.
REQ-010 The block SHALL have port ones, output, 4, registered BCD ones digit.
REQ-011 The block SHALL have port tens, output, 4, registered BCD tens digit.
REQ-012 The block SHALL have ports seg_ones and seg_tens, output, 8 each, combinational 7-segment codes of ones/tens.
REQ-013 The block SHALL have port state, output, 2, FSM encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-014 The block SHALL have port tc, output, 1, registered one-cycle terminal-count pulse.

Function
REQ-015 The block SHALL detect start/stop edges as input high AND a previous-cycle register low; the previous-cycle registers SHALL reset to 0.
REQ-016 Simultaneous start and stop edges: stop SHALL win; start is discarded.
REQ-017 IDLE: start edge -> RUN; load=1 -> load count, remain IDLE; stop ignored.
REQ-018 RUN: stop edge -> PAUSE, count frozen; load ignored; start ignored.
REQ-019 PAUSE: start edge -> RUN; load=1 -> load count and go to IDLE; count otherwise frozen.
REQ-020 DONE: stop edge -> IDLE, count kept; load=1 -> load count and go to IDLE; start ignored.
REQ-021 When load and a stop edge coincide in PAUSE or DONE, load SHALL take effect; destination is IDLE.
REQ-022 Prescaler: the 8-bit counter SHALL be held at 0 outside RUN; in RUN it SHALL increment each cycle and, at PRESCALE-1, assert an internal step and return to 0.
REQ-023 The first step SHALL occur on the PRESCALE-th rising edge after the edge that enters RUN; the prescaler SHALL restart from 0 on every RUN entry.
REQ-024 An up step SHALL produce BCD increment: ones 9->0 with tens+1; 99->00.
REQ-025 A down step SHALL produce BCD decrement: ones 0->9 with tens-1; 00->99.
REQ-026 With oneshot=0, at step 99->00 (up) or 00->99 (down), tc SHALL pulse for one cycle and state SHALL remain RUN.
REQ-027 With oneshot=1, a step that produces 99 (up) or 00 (down) SHALL pulse tc and move to DONE in the same cycle; the count is held.
REQ-028 With oneshot=1, RUN entered while already at the terminal value SHALL still step (and wrap) once before the terminal check applies.
REQ-029 Load SHALL saturate any nibble > 9 to 9 (e.g. 8'hA3 -> tens 9, ones 3).
REQ-030 Loaded value SHALL appear on ones/tens the cycle after the load sample edge; load SHALL never assert tc.
REQ-031 Segment code per digit, in gfedcba with bit7 = 0: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; other values -> 00.

Reset
REQ-032 While reset=1, independent of clk_2: state=IDLE, ones=0, tens=0, tc=0, prescaler=0, edge registers=0; seg_ones=seg_tens=8'h3F.
REQ-033 Reset asserted mid-RUN SHALL abort immediately; after release, the block SHALL wait in IDLE for a new start edge.
REQ-034 If start is held high through reset release, the first clk_2 edge after release SHALL see a start edge (REQ-015) and enter RUN.

Verification (PRESCALE=4)
REQ-035 The bench SHALL cover: reset; start pulse, direction=1, oneshot=0 -> state=1; ones 0->1 on 4th edge after RUN entry; then +1 every 4 cycles.
REQ-036 The bench SHALL cover: load 8'h98 in IDLE; start, up, oneshot=0 -> 98, 99, 00 with tc high exactly one cycle at the 99->00 step; state stays 1.
REQ-037 The bench SHALL cover: load 8'h02, down, oneshot=1, start -> 01, then 00 with tc pulse and state=3; stepping stops; seg_ones=3F.
REQ-038 The bench SHALL cover: in RUN at 05, stop edge -> state=2, count 05 for 20 cycles; start -> first step after 4 cycles to 06.
REQ-039 The bench SHALL cover: start and stop rising in the same cycle from PAUSE -> state stays 2; load 8'hFA in PAUSE -> count 99, state=0.
REQ-040 The bench SHALL cover: reset asserted asynchronously between clock edges in RUN at 47 -> outputs 00/IDLE immediately, before the next clk_2 edge.
